// File: rtl/ps2_note_tracker.sv
// PS/2 scan-code consumer: pops bytes from the receiver FIFO, decodes make/break/E0
// prefixes and tracks up to two held note keys for the frequency lookup.
module ps2_note_tracker #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] kb_data,
    input  logic       kb_ready,
    output logic       kb_nextdata_n,
    output logic [7:0] nowdata,
    output logic [7:0] pastdata,
    output logic       dual,
    output logic       off,
    output logic [7:0] press_count
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_MAKE, S_BREAK, S_EXT, S_EXTBRK} state_t;

    state_t        state_q, state_d;
    logic          pop_q, pop_d;
    logic          nextn_q, nextn_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    now_q, now_d;
    logic [7:0]    past_q, past_d;
    logic [7:0]    count_q, count_d;
    logic          consume;

    function automatic logic is_note(input logic [7:0] b);
        case (b)
            8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
            8'h3D, 8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55: is_note = 1'b1;
            default:                                  is_note = 1'b0;
        endcase
    endfunction

    // One byte per two cycles: the cycle after a pop is the strobe cycle and never consumes.
    assign consume = kb_ready && !pop_q;

    always_comb begin
        state_d = state_q;
        pop_d   = consume;
        nextn_d = !consume;
        cnt_d   = cnt_q;
        now_d   = now_q;
        past_d  = past_q;
        count_d = count_q;
        if (consume) begin
            cnt_d = '0;
            case (state_q)
                S_MAKE: begin
                    if (kb_data == 8'hF0) begin
                        state_d = S_BREAK;
                    end else if (kb_data == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (is_note(kb_data) && kb_data != now_q && kb_data != past_q) begin
                        // A third key pushes the older one out of the past slot.
                        if (now_q != 8'h00) past_d = now_q;
                        now_d   = kb_data;
                        count_d = count_q + 8'd1;
                    end
                end
                S_BREAK: begin
                    state_d = S_MAKE;
                    if (kb_data != 8'hF0 && kb_data != 8'hE0 && kb_data != 8'h00) begin
                        if (kb_data == now_q) begin
                            now_d  = past_q;
                            past_d = 8'h00;
                        end else if (kb_data == past_q) begin
                            past_d = 8'h00;
                        end
                    end
                end
                S_EXT:    state_d = (kb_data == 8'hF0) ? S_EXTBRK : S_MAKE;
                default:  state_d = S_MAKE;
            endcase
        end else if (state_q != S_MAKE) begin
            // A dangling prefix is dropped after a long idle gap.
            if (cnt_q == CNT_LAST) begin
                state_d = S_MAKE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_MAKE;
            pop_q   <= 1'b0;
            nextn_q <= 1'b1;
            cnt_q   <= '0;
            now_q   <= 8'h00;
            past_q  <= 8'h00;
            count_q <= 8'h00;
        end else begin
            state_q <= state_d;
            pop_q   <= pop_d;
            nextn_q <= nextn_d;
            cnt_q   <= cnt_d;
            now_q   <= now_d;
            past_q  <= past_d;
            count_q <= count_d;
        end
    end

    assign kb_nextdata_n = nextn_q;
    assign nowdata       = now_q;
    assign pastdata      = past_q;
    assign press_count   = count_q;
    assign dual          = (past_q != 8'h00);
    assign off           = (now_q == 8'h00);

endmodule

// File: tb/tb_ps2_note_tracker.sv
// Bench for ps2_note_tracker: FIFO model feeding directed and random scan-code
// streams, with a held-key list model checked every cycle.
module tb_ps2_note_tracker;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       kb_nextdata_n;
    logic [7:0] nowdata, pastdata, press_count;
    logic       dual, off;

    ps2_note_tracker #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_nextdata_n(kb_nextdata_n), .nowdata(nowdata), .pastdata(pastdata),
        .dual(dual), .off(off), .press_count(press_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] fifo[$];
    bit         en = 1'b1;
    bit         m_pend;
    logic [7:0] held[$];
    logic [7:0] m_count;
    int         m_prefix;  // 0 none, 1 after F0, 2 after E0, 3 after E0 F0
    int         m_idle;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_note(input logic [7:0] b);
        logic [7:0] notes[12] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                  8'h3D, 8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55};
        foreach (notes[i]) if (notes[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] exp_now();
        return (held.size() > 0) ? held[held.size()-1] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_past();
        return (held.size() > 1) ? held[held.size()-2] : 8'h00;
    endfunction

    task automatic press(input logic [7:0] b);
        if (!is_note(b)) return;
        foreach (held[i]) if (held[i] == b) return;
        held.push_back(b);
        if (held.size() > 2) void'(held.pop_front());
        m_count++;
    endtask

    task automatic release_key(input logic [7:0] b);
        for (int i = held.size() - 1; i >= 0; i--)
            if (held[i] == b) held.delete(i);
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_prefix)
            0: begin
                if (b == 8'hF0) m_prefix = 1;
                else if (b == 8'hE0) m_prefix = 2;
                else press(b);
            end
            1: begin
                m_prefix = 0;
                if (b != 8'hF0 && b != 8'hE0) release_key(b);
            end
            2: m_prefix = (b == 8'hF0) ? 3 : 0;
            default: m_prefix = 0;
        endcase
    endtask

    task automatic drive();
        kb_ready = en && (fifo.size() > 0);
        kb_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".now"},    nowdata,        exp_now());
        chk({tag, ".past"},   pastdata,       exp_past());
        chk({tag, ".dual"},   {7'd0, dual},   {7'd0, exp_past() != 8'h00});
        chk({tag, ".off"},    {7'd0, off},    {7'd0, exp_now() == 8'h00});
        chk({tag, ".count"},  press_count,    m_count);
        chk({tag, ".strobe"}, {7'd0, kb_nextdata_n}, {7'd0, !m_pend});
    endtask

    task automatic tick(input string tag);
        bit         c;
        logic [7:0] b;
        c = kb_ready && !m_pend;
        b = kb_data;
        @(posedge clk);
        if (c) begin
            model_byte(b);
            m_idle = 0;
        end else if (m_prefix != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_prefix = 0;
                m_idle   = 0;
            end
        end
        m_pend = c;
        #1;
        check_all(tag);
        if (c) void'(fifo.pop_front());
        drive();
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        held.delete();
        m_count = 8'h00; m_prefix = 0; m_idle = 0; m_pend = 1'b0;
        #1 check_all(tag);
        #1 rst = 1'b0;
        drive();
    endtask

    task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        fifo.push_back(a); fifo.push_back(b); fifo.push_back(c);
    endtask

    initial begin
        int         lows;
        logic [7:0] pool[20] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55, 8'hF0, 8'hF0,
                                 8'hF0, 8'hE0, 8'h1C, 8'h15, 8'h00, 8'h16};
        #7;
        do_reset("init");

        // T1: reset in the strobe cycle of a pop
        fifo.push_back(8'h1C); drive();
        tick("t1");
        chk("t1.strobe_low", {7'd0, kb_nextdata_n}, 8'h00);
        do_reset("t1.rst");
        fifo.delete(); drive();
        run("t1.post", 2);

        // T2: non-note press ignored, note press/release
        push3(8'h15, 8'hF0, 8'h15); drive();
        run("t2a", 8);
        chk("t2.count0", press_count, 8'h00);
        push3(8'h16, 8'hF0, 8'h16); drive();
        run("t2b", 1);
        chk("t2.now16", nowdata, 8'h16);
        chk("t2.off0", {7'd0, off}, 8'h00);
        run("t2c", 6);
        chk("t2.now0", nowdata, 8'h00);
        chk("t2.count1", press_count, 8'h01);

        // T3: three keys, eviction, release newest
        do_reset("t3.rst");
        push3(8'h16, 8'h1E, 8'h26); drive();
        run("t3a", 6);
        chk("t3.now", nowdata, 8'h26);
        chk("t3.past", pastdata, 8'h1E);
        chk("t3.dual", {7'd0, dual}, 8'h01);
        chk("t3.count", press_count, 8'h03);
        fifo.push_back(8'hF0); fifo.push_back(8'h26); drive();
        run("t3b", 5);
        chk("t3.now2", nowdata, 8'h1E);
        chk("t3.past2", pastdata, 8'h00);

        // T4: typematic repeat, release of older key, unmatched release
        do_reset("t4.rst");
        push3(8'h16, 8'h16, 8'h16); drive();
        run("t4a", 7);
        chk("t4.count", press_count, 8'h01);
        push3(8'h1E, 8'hF0, 8'h16); fifo.push_back(8'hF0); fifo.push_back(8'h55); drive();
        run("t4b", 11);
        chk("t4.now", nowdata, 8'h1E);
        chk("t4.past", pastdata, 8'h00);

        // T5: extended sequences ignored; F0 prefix expires after TO idle cycles
        do_reset("t5.rst");
        fifo.push_back(8'hE0); fifo.push_back(8'h16);
        push3(8'hE0, 8'hF0, 8'h16); drive();
        run("t5a", 12);
        chk("t5.ext_now", nowdata, 8'h00);
        fifo.push_back(8'hF0); drive();
        run("t5b", 1 + TO);
        fifo.push_back(8'h16); drive();
        run("t5c", 3);
        chk("t5.timeout_now", nowdata, 8'h16);
        // one cycle short of expiry: prefix still live, so 16 is a release
        fifo.push_back(8'hF0); drive();
        run("t5d", TO);
        fifo.push_back(8'h16); drive();
        run("t5e", 3);
        chk("t5.live_now", nowdata, 8'h00);

        // T6: six queued bytes give six single-cycle strobes two cycles apart
        do_reset("t6.rst");
        for (int i = 0; i < 6; i++) fifo.push_back(8'h1C);
        drive();
        lows = 0;
        for (int i = 0; i < 14; i++) begin
            tick("t6");
            if (!kb_nextdata_n) lows++;
        end
        chk("t6.lows", 8'(lows), 8'd6);

        // Random streams with random FIFO availability and occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) != 0 && fifo.size() < 8)
                fifo.push_back(pool[$urandom_range(0, 19)]);
            en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 60) == 0) en = 1'b0;
            drive();
            if ($urandom_range(0, 400) == 0) do_reset("rnd.rst");
            else tick("rnd");
            if ($urandom_range(0, 90) == 0) begin
                en = 1'b0; drive();
                run("rnd.idle", TO + $urandom_range(0, 2) - 1);
                en = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
